tilemap_sr_array: RTL and testbench

TILEMAP_SR_ARRAY -- requirements
Module: tilemap_sr_array

---
 rtl/tilemap_sr_array.sv | 176 +++++++++++++++++
 tb/tb_tilemap_sr_array.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tilemap_sr_array.sv
// tilemap_sr_array: per-channel tile-line latch, 8-pixel shift register,
// flip tap select and programmable output delay line.
// Optional feature macro: TILEMAP_SR_PRIORITY_MIX_EN adds a registered
// lowest-index-opaque-channel priority mixer (o_MIX_PIXEL / o_MIX_SEL).
module tilemap_sr_array #(
  parameter  int CH        = 2,
  parameter  int BPP       = 4,
  parameter  int DMAX      = 3,
  parameter  int LATCH_PH0 = 7,
  parameter  int PH_STEP   = 4,
  localparam int DW        = $clog2(DMAX + 1)
) (
  input  logic                i_EMU_MCLK,
  input  logic                i_EMU_RST_n,
  input  logic                i_EMU_CLK6MPCEN_n,
  input  logic [2:0]          i_PIXPHASE,
  input  logic [8*BPP-1:0]    i_GFXDATA,
  input  logic [2*CH-1:0]     i_MODE,
  input  logic [CH-1:0]       i_FLIP,
  input  logic [DW*CH-1:0]    i_DLY,
  output logic [BPP*CH-1:0]   o_PIXEL,
  output logic [CH-1:0]       o_TRN_n
`ifdef TILEMAP_SR_PRIORITY_MIX_EN
  ,
  output logic [BPP-1:0]      o_MIX_PIXEL,
  output logic [CH-1:0]       o_MIX_SEL
`endif
);

  typedef logic [BPP-1:0] pix_t;

  // Latch phase of a channel; the 3-bit cast performs the wrap modulo 8.
  function automatic logic [2:0] latch_ph(input int c);
    latch_ph = 3'(LATCH_PH0 + c * PH_STEP);
  endfunction

  logic [8*BPP-1:0] latch_q [CH];
  logic [8*BPP-1:0] latch_d [CH];
  pix_t             sr_q    [CH][8];
  pix_t             sr_d    [CH][8];
  pix_t             dl_q    [CH][DMAX];
  pix_t             dl_d    [CH][DMAX];
  pix_t             tap_s   [CH];
  pix_t             pix_s   [CH];
  logic [DW-1:0]    dsel_s  [CH];

  // Tap select and output delay mux; purely combinational so flip/delay act at once.
  always_comb begin
    o_PIXEL = {(BPP*CH){1'b0}};
    o_TRN_n = {CH{1'b0}};
    for (int c = 0; c < CH; c++) begin
      tap_s[c]  = i_FLIP[c] ? sr_q[c][7] : sr_q[c][0];
      dsel_s[c] = i_DLY[c*DW +: DW];
      if (dsel_s[c] == {DW{1'b0}}) begin
        pix_s[c] = tap_s[c];
      end else if (dsel_s[c] >= DW'(DMAX)) begin
        pix_s[c] = dl_q[c][DMAX-1];
      end else begin
        pix_s[c] = dl_q[c][dsel_s[c] - 1'b1];
      end
      o_PIXEL[c*BPP +: BPP] = pix_s[c];
      o_TRN_n[c]            = |pix_s[c];
    end
  end

  // Next-state for latch, shift register and delay line; everything holds unless enabled.
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      latch_d[c] = latch_q[c];
      sr_d[c]    = sr_q[c];
      dl_d[c]    = dl_q[c];
      if (!i_EMU_CLK6MPCEN_n) begin
        if (i_PIXPHASE == latch_ph(c)) begin
          latch_d[c] = i_GFXDATA;
        end else begin
          latch_d[c] = latch_q[c];
        end
        // Parallel load reads latch_q, so a same-edge strobe loads the older line.
        case (i_MODE[2*c +: 2])
          2'b00: sr_d[c] = sr_q[c];
          2'b01: begin
            for (int n = 7; n > 0; n--) begin
              sr_d[c][n] = sr_q[c][n-1];
            end
            sr_d[c][0] = {BPP{1'b0}};
          end
          2'b10: begin
            for (int n = 0; n < 7; n++) begin
              sr_d[c][n] = sr_q[c][n+1];
            end
            sr_d[c][7] = {BPP{1'b0}};
          end
          2'b11: begin
            for (int n = 0; n < 8; n++) begin
              sr_d[c][n] = latch_q[c][(7-n)*BPP +: BPP];
            end
          end
          default: sr_d[c] = sr_q[c];
        endcase
        dl_d[c][0] = tap_s[c];
        for (int k = 1; k < DMAX; k++) begin
          dl_d[c][k] = dl_q[c][k-1];
        end
      end else begin
        latch_d[c] = latch_q[c];
        sr_d[c]    = sr_q[c];
        dl_d[c]    = dl_q[c];
      end
    end
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge i_EMU_MCLK) begin
    if (!i_EMU_RST_n) begin
      for (int c = 0; c < CH; c++) begin
        latch_q[c] <= '0;
        for (int n = 0; n < 8; n++) begin
          sr_q[c][n] <= '0;
        end
        for (int k = 0; k < DMAX; k++) begin
          dl_q[c][k] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        latch_q[c] <= latch_d[c];
        sr_q[c]    <= sr_d[c];
        dl_q[c]    <= dl_d[c];
      end
    end
  end

`ifdef TILEMAP_SR_PRIORITY_MIX_EN
  pix_t          mix_pixel_q;
  pix_t          mix_pixel_d;
  logic [CH-1:0] mix_sel_q;
  logic [CH-1:0] mix_sel_d;

  // Priority mix: scanning from the top down lets the lowest opaque channel win.
  always_comb begin
    mix_pixel_d = mix_pixel_q;
    mix_sel_d   = mix_sel_q;
    if (!i_EMU_CLK6MPCEN_n) begin
      mix_pixel_d = {BPP{1'b0}};
      mix_sel_d   = {CH{1'b0}};
      for (int c = CH - 1; c >= 0; c--) begin
        if (o_TRN_n[c]) begin
          mix_pixel_d = pix_s[c];
          mix_sel_d   = CH'(1'b1) << c;
        end else begin
          mix_pixel_d = mix_pixel_d;
          mix_sel_d   = mix_sel_d;
        end
      end
    end else begin
      mix_pixel_d = mix_pixel_q;
      mix_sel_d   = mix_sel_q;
    end
  end

  // Mix output registers with synchronous active-low clear.
  always_ff @(posedge i_EMU_MCLK) begin
    if (!i_EMU_RST_n) begin
      mix_pixel_q <= '0;
      mix_sel_q   <= '0;
    end else begin
      mix_pixel_q <= mix_pixel_d;
      mix_sel_q   <= mix_sel_d;
    end
  end

  assign o_MIX_PIXEL = mix_pixel_q;
  assign o_MIX_SEL   = mix_sel_q;
`endif

endmodule

// File: tb/tb_tilemap_sr_array.sv
// Self-checking bench for tilemap_sr_array: directed scenarios with literal
// expectations plus randomized traffic against a pixel-list reference model.
module tb_tilemap_sr_array;

  localparam int CH   = 2;
  localparam int BPP  = 4;
  localparam int DMAX = 3;
  localparam int DW   = $clog2(DMAX + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n, cen_n;
  logic [2:0]          phase;
  logic [8*BPP-1:0]    gfx;
  logic [2*CH-1:0]     mode;
  logic [CH-1:0]       flip;
  logic [DW*CH-1:0]    dly;
  logic [BPP*CH-1:0]   pix;
  logic [CH-1:0]       trn;
`ifdef TILEMAP_SR_PRIORITY_MIX_EN
  logic [BPP-1:0]      mix_pix;
  logic [CH-1:0]       mix_sel;
`endif

  tilemap_sr_array #(.CH(CH), .BPP(BPP), .DMAX(DMAX), .LATCH_PH0(7), .PH_STEP(4)) dut (
    .i_EMU_MCLK        (clk),
    .i_EMU_RST_n       (rst_n),
    .i_EMU_CLK6MPCEN_n (cen_n),
    .i_PIXPHASE        (phase),
    .i_GFXDATA         (gfx),
    .i_MODE            (mode),
    .i_FLIP            (flip),
    .i_DLY             (dly),
    .o_PIXEL           (pix),
    .o_TRN_n           (trn)
`ifdef TILEMAP_SR_PRIORITY_MIX_EN
    ,
    .o_MIX_PIXEL       (mix_pix),
    .o_MIX_SEL         (mix_sel)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: latched line and visible line as 8-pixel lists, plus a
  // history of past tap values (m_hist[c][k] = tap k enabled edges ago).
  logic [BPP-1:0] m_latch [CH][8];
  logic [BPP-1:0] m_line  [CH][8];
  logic [BPP-1:0] m_hist  [CH][DMAX+1];
  logic [BPP-1:0] m_mix_pix;
  logic [CH-1:0]  m_mix_sel;

  function automatic logic [BPP-1:0] exp_pix(input int c);
    logic [BPP-1:0] t;
    int d;
    t = flip[c] ? m_line[c][7] : m_line[c][0];
    d = int'(dly[c*DW +: DW]);
    if (d == 0) return t;
    if (d > DMAX) d = DMAX;
    return m_hist[c][d];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
    end
  endtask

  task automatic check_model();
    for (int c = 0; c < CH; c++) begin
      check($sformatf("model_pix%0d", c), 32'(pix[c*BPP +: BPP]), 32'(exp_pix(c)));
      check($sformatf("model_trn%0d", c), 32'(trn[c]), 32'(exp_pix(c) != '0));
    end
`ifdef TILEMAP_SR_PRIORITY_MIX_EN
    check("model_mix_pix", 32'(mix_pix), 32'(m_mix_pix));
    check("model_mix_sel", 32'(mix_sel), 32'(m_mix_sel));
`endif
  endtask

  task automatic model_step();
    logic [BPP-1:0] taps [CH];
    logic [BPP-1:0] old  [8];
    bit found;
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        for (int i = 0; i < 8; i++) begin
          m_latch[c][i] = '0;
          m_line[c][i]  = '0;
        end
        for (int k = 0; k <= DMAX; k++) m_hist[c][k] = '0;
      end
      m_mix_pix = '0;
      m_mix_sel = '0;
    end else if (!cen_n) begin
      found = 1'b0;
      m_mix_pix = '0;
      m_mix_sel = '0;
      for (int c = 0; c < CH; c++) begin
        taps[c] = flip[c] ? m_line[c][7] : m_line[c][0];
        if (!found && exp_pix(c) != '0) begin
          found = 1'b1;
          m_mix_pix = exp_pix(c);
          m_mix_sel = CH'(1) << c;
        end
      end
      for (int c = 0; c < CH; c++) begin
        for (int k = DMAX; k >= 2; k--) m_hist[c][k] = m_hist[c][k-1];
        m_hist[c][1] = taps[c];
        old = m_line[c];
        case (mode[2*c +: 2])
          2'b01: for (int n = 0; n < 8; n++) m_line[c][n] = (n == 0) ? '0 : old[n-1];
          2'b10: for (int n = 0; n < 8; n++) m_line[c][n] = (n == 7) ? '0 : old[n+1];
          2'b11: m_line[c] = m_latch[c];
          default: ;
        endcase
        if (int'(phase) == (7 + c * 4) % 8) begin
          for (int i = 0; i < 8; i++) m_latch[c][i] = gfx[(7-i)*BPP +: BPP];
        end
      end
    end
  endtask

  // One clock: advance the model on the edge, then compare shortly after it.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #2;
    check_model();
  endtask

  int exp_fwd [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 0};
  int exp_rev [9] = '{8, 7, 6, 5, 4, 3, 2, 1, 0};
  logic [BPP-1:0] s0 [$];

  initial begin
    rst_n = 1'b0; cen_n = 1'b0; phase = 3'd0; gfx = '0;
    mode = '0; flip = '0; dly = '0;
    cycle();
    cycle();
    check("reset_pix", 32'(pix), 32'd0);
    check("reset_trn", 32'(trn), 32'd0);
    rst_n = 1'b1;

    // Forward shift of 0x12345678 through channel 0.
    gfx = 32'h1234_5678; phase = 3'd7; mode = 4'b0000;
    cycle();
    phase = 3'd0; mode = 4'b0011;
    cycle();
    check("fwd_0", 32'(pix[3:0]), 32'(exp_fwd[0]));
    for (int i = 1; i < 9; i++) begin
      mode = 4'b0010;
      cycle();
      check($sformatf("fwd_%0d", i), 32'(pix[3:0]), 32'(exp_fwd[i]));
    end

    // Flipped tap with left shift.
    flip = 2'b01; phase = 3'd7; mode = 4'b0000;
    cycle();
    phase = 3'd0; mode = 4'b0011;
    cycle();
    check("rev_0", 32'(pix[3:0]), 32'(exp_rev[0]));
    for (int i = 1; i < 9; i++) begin
      mode = 4'b0001;
      cycle();
      check($sformatf("rev_%0d", i), 32'(pix[3:0]), 32'(exp_rev[i]));
    end

    // Channel-specific latch phases.
    flip = 2'b00; mode = 4'b0000;
    gfx = 32'hAAAA_AAAA; phase = 3'd3;
    cycle();
    gfx = 32'h5555_5555; phase = 3'd7;
    cycle();
    phase = 3'd0; mode = 4'b1111;
    cycle();
    check("phase_ch0", 32'(pix[3:0]), 32'h5);
    check("phase_ch1", 32'(pix[7:4]), 32'hA);
    check("phase_trn", 32'(trn), 32'h3);

    // Reset mid-shift while the pixel enable is inactive.
    mode = 4'b1010;
    cycle();
    cycle();
    rst_n = 1'b0; cen_n = 1'b1;
    cycle();
    check("rst_mid_pix", 32'(pix), 32'd0);
    check("rst_mid_trn", 32'(trn), 32'd0);
    rst_n = 1'b1; cen_n = 1'b0;

    // Same stream in both channels; channel 1 viewed through a 3-edge delay.
    mode = 4'b0000; dly = 4'b1100; gfx = 32'h9ABC_DEF1; phase = 3'd3;
    cycle();
    phase = 3'd7;
    cycle();
    phase = 3'd0; mode = 4'b1111;
    cycle();
    s0.push_back(pix[3:0]);
    check("dly_first", 32'(pix[3:0]), 32'h9);
    for (int n = 1; n < 12; n++) begin
      mode = (n <= 7) ? 4'b1010 : 4'b0000;
      cycle();
      s0.push_back(pix[3:0]);
      if (n >= 3) check($sformatf("dly3_%0d", n), 32'(pix[7:4]), 32'(s0[n-3]));
    end

`ifdef TILEMAP_SR_PRIORITY_MIX_EN
    // Channel 0 transparent, channel 1 shows 9: the mixer picks channel 1.
    rst_n = 1'b0; dly = '0; mode = 4'b0000;
    cycle();
    rst_n = 1'b1; gfx = 32'h9000_0000; phase = 3'd3;
    cycle();
    phase = 3'd0; mode = 4'b1100;
    cycle();
    mode = 4'b0000;
    cycle();
    check("mix_pix", 32'(mix_pix), 32'h9);
    check("mix_sel", 32'(mix_sel), 32'h2);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      cen_n = ($urandom_range(0, 3) == 0);
      phase = 3'($urandom);
      gfx   = $urandom;
      for (int c = 0; c < CH; c++) begin
        case ($urandom_range(0, 7))
          0: mode[2*c +: 2] = 2'b11;
          1: mode[2*c +: 2] = 2'b00;
          default: mode[2*c +: 2] = $urandom_range(0, 1) ? 2'b01 : 2'b10;
        endcase
      end
      flip = CH'($urandom);
      dly  = (DW*CH)'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
